// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX stage: widths, ALU encodings, the
// registered ID/EX record, its bubble value and the forwarding-hit predicate.
package pipe_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic                src_a_pc;
        logic                src_b_imm;
        logic                reg_we;
        logic                mem_rd;
        logic                mem_wr;
    } id_ex_t;

    // A bubble is the all-zero record; it is also the reset value.
    localparam id_ex_t BUBBLE = '{
        valid:     1'b0,
        pc:        32'h0000_0000,
        rs1_data:  32'h0000_0000,
        rs2_data:  32'h0000_0000,
        imm:       32'h0000_0000,
        rs1:       5'd0,
        rs2:       5'd0,
        rd:        5'd0,
        alu_op:    ALU_ADD,
        src_a_pc:  1'b0,
        src_b_imm: 1'b0,
        reg_we:    1'b0,
        mem_rd:    1'b0,
        mem_wr:    1'b0
    };

    // x0 is hard-wired to zero, so a producer targeting it never forwards.
    function automatic logic fwd_hit(input logic              reg_we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return reg_we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, forward sources and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if import pipe_pkg::*; ();

    logic                stall;
    logic                flush;
    logic                id_valid;
    logic [XLEN-1:0]     id_pc;
    logic [XLEN-1:0]     id_rs1_data;
    logic [XLEN-1:0]     id_rs2_data;
    logic [XLEN-1:0]     id_imm;
    logic [REG_AW-1:0]   id_rs1;
    logic [REG_AW-1:0]   id_rs2;
    logic [REG_AW-1:0]   id_rd;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                id_src_a_pc;
    logic                id_src_b_imm;
    logic                id_reg_we;
    logic                id_mem_rd;
    logic                id_mem_wr;

    logic [REG_AW-1:0]   exm_rd;
    logic                exm_reg_we;
    logic [XLEN-1:0]     exm_result;
    logic [REG_AW-1:0]   mwb_rd;
    logic                mwb_reg_we;
    logic [XLEN-1:0]     mwb_result;

    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                ex_valid;
    logic [REG_AW-1:0]   ex_rd;
    logic                ex_reg_we;
    logic                ex_mem_rd;
    logic                ex_mem_wr;
    logic [XLEN-1:0]     ex_pc;
    logic [XLEN-1:0]     ex_store_data;
    logic                load_use;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_src_a_pc, id_src_b_imm,
               id_reg_we, id_mem_rd, id_mem_wr,
               exm_rd, exm_reg_we, exm_result, mwb_rd, mwb_reg_we, mwb_result,
        input  alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_reg_we, ex_mem_rd,
               ex_mem_wr, ex_pc, ex_store_data, load_use
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_src_a_pc, id_src_b_imm,
               id_reg_we, id_mem_rd, id_mem_wr,
               exm_rd, exm_reg_we, exm_result, mwb_rd, mwb_reg_we, mwb_result,
        output alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_reg_we, ex_mem_rd,
               ex_mem_wr, ex_pc, ex_store_data, load_use
    );

endinterface

// File: rtl/fwd_mux.sv
// Operand forward select for one source register: EX/MEM beats MEM/WB beats regfile.
module fwd_mux import pipe_pkg::*; (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [XLEN-1:0]   reg_data_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              exm_reg_we_i,
    input  logic [XLEN-1:0]   exm_result_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic              mwb_reg_we_i,
    input  logic [XLEN-1:0]   mwb_result_i,
    output logic [XLEN-1:0]   data_o
);

    // Youngest producer wins on a double hit.
    always_comb begin
        data_o = reg_data_i;
        if (fwd_hit(exm_reg_we_i, exm_rd_i, rs_i)) begin
            data_o = exm_result_i;
        end else if (fwd_hit(mwb_reg_we_i, mwb_rd_i, rs_i)) begin
            data_o = mwb_result_i;
        end else begin
            data_o = reg_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
module id_ex_stage import pipe_pkg::*; (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    id_ex_t          id_fields_s;
    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;

    assign id_fields_s = '{
        valid:     1'b1,
        pc:        bus.id_pc,
        rs1_data:  bus.id_rs1_data,
        rs2_data:  bus.id_rs2_data,
        imm:       bus.id_imm,
        rs1:       bus.id_rs1,
        rs2:       bus.id_rs2,
        rd:        bus.id_rd,
        alu_op:    bus.id_alu_op,
        src_a_pc:  bus.id_src_a_pc,
        src_b_imm: bus.id_src_b_imm,
        reg_we:    bus.id_reg_we,
        mem_rd:    bus.id_mem_rd,
        mem_wr:    bus.id_mem_wr
    };

    // Next-state select: flush beats stall; an empty ID slot loads a bubble.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = BUBBLE;
        end else if (bus.stall) begin
            ex_d = ex_q;
        end else if (bus.id_valid) begin
            ex_d = id_fields_s;
        end else begin
            ex_d = BUBBLE;
        end
    end

    // ID/EX state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs_i         (ex_q.rs1),
        .reg_data_i   (ex_q.rs1_data),
        .exm_rd_i     (bus.exm_rd),
        .exm_reg_we_i (bus.exm_reg_we),
        .exm_result_i (bus.exm_result),
        .mwb_rd_i     (bus.mwb_rd),
        .mwb_reg_we_i (bus.mwb_reg_we),
        .mwb_result_i (bus.mwb_result),
        .data_o       (fwd_rs1_s)
    );

    fwd_mux u_fwd_rs2 (
        .rs_i         (ex_q.rs2),
        .reg_data_i   (ex_q.rs2_data),
        .exm_rd_i     (bus.exm_rd),
        .exm_reg_we_i (bus.exm_reg_we),
        .exm_result_i (bus.exm_result),
        .mwb_rd_i     (bus.mwb_rd),
        .mwb_reg_we_i (bus.mwb_reg_we),
        .mwb_result_i (bus.mwb_result),
        .data_o       (fwd_rs2_s)
    );

    assign bus.alu_a         = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1_s;
    assign bus.alu_b         = ex_q.src_b_imm ? ex_q.imm : fwd_rs2_s;
    assign bus.ex_store_data = fwd_rs2_s;
    assign bus.alu_op        = ex_q.alu_op;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_we     = ex_q.reg_we;
    assign bus.ex_mem_rd     = ex_q.mem_rd;
    assign bus.ex_mem_wr     = ex_q.mem_wr;
    assign bus.ex_pc         = ex_q.pc;

    // Not qualified by instruction format: a spurious match only costs a stall.
    assign bus.load_use = ex_q.valid && ex_q.mem_rd && (ex_q.rd != 5'd0) && bus.id_valid &&
                          ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX-side instruction slot.
module tb_id_ex_stage import pipe_pkg::*; ();

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model of the instruction currently sitting in EX.
    logic                m_valid;
    logic [XLEN-1:0]     m_pc, m_d1, m_d2, m_imm;
    logic [REG_AW-1:0]   m_rs1, m_rs2, m_rd;
    logic [ALU_OP_W-1:0] m_op;
    logic                m_srca, m_srcb, m_we, m_ld, m_st;

    task automatic chk_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_empty();
        m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_op = '0;
        m_srca = 1'b0; m_srcb = 1'b0; m_we = 1'b0; m_ld = 1'b0; m_st = 1'b0;
    endtask

    task automatic model_edge();
        if (bus.flush || (!bus.stall && !bus.id_valid)) begin
            model_empty();
        end else if (!bus.stall) begin
            m_valid = 1'b1;          m_pc  = bus.id_pc;
            m_d1 = bus.id_rs1_data;  m_d2  = bus.id_rs2_data; m_imm = bus.id_imm;
            m_rs1 = bus.id_rs1;      m_rs2 = bus.id_rs2;      m_rd  = bus.id_rd;
            m_op = bus.id_alu_op;    m_srca = bus.id_src_a_pc; m_srcb = bus.id_src_b_imm;
            m_we = bus.id_reg_we;    m_ld = bus.id_mem_rd;    m_st = bus.id_mem_wr;
        end
    endtask

    function automatic logic [XLEN-1:0] exp_fwd(input logic [REG_AW-1:0] rs, input logic [XLEN-1:0] own);
        if (rs == 5'd0) return own;
        if (bus.exm_reg_we && bus.exm_rd == rs) return bus.exm_result;
        if (bus.mwb_reg_we && bus.mwb_rd == rs) return bus.mwb_result;
        return own;
    endfunction

    task automatic check_all();
        logic exp_lu;
        exp_lu = m_valid && m_ld && (m_rd != 5'd0) && bus.id_valid &&
                 ((m_rd == bus.id_rs1) || (m_rd == bus.id_rs2));
        chk_eq("ex_valid",  32'(bus.ex_valid),  32'(m_valid));
        chk_eq("ex_rd",     32'(bus.ex_rd),     32'(m_rd));
        chk_eq("ex_reg_we", 32'(bus.ex_reg_we), 32'(m_we));
        chk_eq("ex_mem_rd", 32'(bus.ex_mem_rd), 32'(m_ld));
        chk_eq("ex_mem_wr", 32'(bus.ex_mem_wr), 32'(m_st));
        chk_eq("ex_pc",     bus.ex_pc,          m_pc);
        chk_eq("alu_op",    32'(bus.alu_op),    32'(m_op));
        chk_eq("alu_a",     bus.alu_a,          m_srca ? m_pc : exp_fwd(m_rs1, m_d1));
        chk_eq("alu_b",     bus.alu_b,          m_srcb ? m_imm : exp_fwd(m_rs2, m_d2));
        chk_eq("store_data", bus.ex_store_data, exp_fwd(m_rs2, m_d2));
        chk_eq("load_use",  32'(bus.load_use),  32'(exp_lu));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic drive_idle();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
        bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_alu_op = ALU_ADD;
        bus.id_src_a_pc = 1'b0; bus.id_src_b_imm = 1'b0;
        bus.id_reg_we = 1'b0; bus.id_mem_rd = 1'b0; bus.id_mem_wr = 1'b0;
        bus.exm_rd = '0; bus.exm_reg_we = 1'b0; bus.exm_result = '0;
        bus.mwb_rd = '0; bus.mwb_reg_we = 1'b0; bus.mwb_result = '0;
    endtask

    task automatic drive_random();
        bus.flush        = ($urandom_range(0, 7) == 0);
        bus.stall        = ($urandom_range(0, 3) == 0);
        bus.id_valid     = ($urandom_range(0, 3) != 0);
        bus.id_pc        = $urandom;
        bus.id_rs1_data  = $urandom;
        bus.id_rs2_data  = $urandom;
        bus.id_imm       = $urandom;
        bus.id_rs1       = REG_AW'($urandom_range(0, 7));
        bus.id_rs2       = REG_AW'($urandom_range(0, 7));
        bus.id_rd        = REG_AW'($urandom_range(0, 7));
        bus.id_alu_op    = ALU_OP_W'($urandom_range(0, 15));
        bus.id_src_a_pc  = 1'($urandom_range(0, 1));
        bus.id_src_b_imm = 1'($urandom_range(0, 1));
        bus.id_reg_we    = 1'($urandom_range(0, 1));
        bus.id_mem_rd    = 1'($urandom_range(0, 1));
        bus.id_mem_wr    = 1'($urandom_range(0, 1));
        bus.exm_rd       = REG_AW'($urandom_range(0, 7));
        bus.exm_reg_we   = 1'($urandom_range(0, 1));
        bus.exm_result   = $urandom;
        bus.mwb_rd       = REG_AW'($urandom_range(0, 7));
        bus.mwb_reg_we   = 1'($urandom_range(0, 1));
        bus.mwb_result   = $urandom;
    endtask

    initial begin
        logic [XLEN-1:0] held_pc;
        drive_idle();
        model_empty();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Reset asserted mid-cycle clears the slot without a clock edge.
        bus.id_valid = 1'b1; bus.id_pc = 32'h0000_0100; bus.id_alu_op = ALU_SUB;
        bus.id_reg_we = 1'b1; bus.id_mem_rd = 1'b1; bus.id_rd = 5'd9;
        tick();
        #2;
        rst_n = 1'b0;
        model_empty();
        #1;
        chk_eq("rst_valid",  32'(bus.ex_valid),  32'd0);
        chk_eq("rst_alu_op", 32'(bus.alu_op),    32'd0);
        chk_eq("rst_reg_we", 32'(bus.ex_reg_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();

        // Plain capture: a = rs1 data, b = immediate.
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rd = 5'd3;
        bus.id_rs1_data = 32'd5; bus.id_imm = 32'd7; bus.id_src_b_imm = 1'b1;
        bus.id_alu_op = ALU_ADD;
        tick();
        chk_eq("cap_a", bus.alu_a, 32'd5);
        chk_eq("cap_b", bus.alu_b, 32'd7);

        // Double hit on rs1=3, then EX/MEM drops out.
        drive_idle();
        bus.id_valid = 1'b1; bus.id_rs1 = 5'd3; bus.id_rs1_data = 32'h0000_1111;
        tick();
        bus.exm_rd = 5'd3; bus.exm_result = 32'h0000_AAAA; bus.exm_reg_we = 1'b1;
        bus.mwb_rd = 5'd3; bus.mwb_result = 32'h0000_5555; bus.mwb_reg_we = 1'b1;
        #1;
        chk_eq("dbl_hit_a", bus.alu_a, 32'h0000_AAAA);
        bus.exm_reg_we = 1'b0;
        #1;
        chk_eq("mwb_hit_a", bus.alu_a, 32'h0000_5555);

        // x0 is never forwarded.
        drive_idle();
        bus.id_valid = 1'b1; bus.id_rs2 = 5'd0; bus.id_rs2_data = 32'd0;
        bus.exm_rd = 5'd0; bus.exm_reg_we = 1'b1; bus.exm_result = 32'h0000_FFFF;
        tick();
        chk_eq("x0_alu_b", bus.alu_b, 32'd0);
        chk_eq("x0_store", bus.ex_store_data, 32'd0);

        // Load-use, then the hazard unit flushes this stage and stalls.
        drive_idle();
        bus.id_valid = 1'b1; bus.id_rd = 5'd4; bus.id_reg_we = 1'b1; bus.id_mem_rd = 1'b1;
        tick();
        bus.id_mem_rd = 1'b0; bus.id_rd = 5'd6; bus.id_rs1 = 5'd4; bus.id_rs2 = 5'd7;
        #1;
        chk_eq("load_use_hit", 32'(bus.load_use), 32'd1);
        bus.flush = 1'b1;
        tick();
        chk_eq("lu_flush_valid", 32'(bus.ex_valid), 32'd0);
        bus.flush = 1'b0; bus.stall = 1'b1;
        repeat (3) tick();
        chk_eq("lu_stall_valid", 32'(bus.ex_valid), 32'd0);

        // Stall holds a real instruction for three cycles.
        drive_idle();
        bus.id_valid = 1'b1; bus.id_pc = 32'h0000_0440; bus.id_rd = 5'd5; bus.id_reg_we = 1'b1;
        tick();
        held_pc = 32'h0000_0440;
        bus.stall = 1'b1; bus.id_pc = 32'h0000_0880; bus.id_rd = 5'd2;
        repeat (3) tick();
        chk_eq("stall_pc", bus.ex_pc, held_pc);
        chk_eq("stall_rd", 32'(bus.ex_rd), 32'd5);

        // Reset while stalled clears the slot.
        #2;
        rst_n = 1'b0;
        model_empty();
        #1;
        chk_eq("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Flush and stall together load a bubble.
        drive_idle();
        bus.id_valid = 1'b1; bus.id_mem_wr = 1'b1; bus.id_rs2 = 5'd8;
        tick();
        bus.flush = 1'b1; bus.stall = 1'b1;
        tick();
        chk_eq("fs_valid",  32'(bus.ex_valid),  32'd0);
        chk_eq("fs_mem_wr", 32'(bus.ex_mem_wr), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            #1;
            check_all();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
